pcs_64b66b_decoder: RTL

- Receive-side 64b/66b block decoder.
- Sits between the descrambler and the MAC receive path.
- Accepts each 66-bit block as two 32-bit halves with a 2-bit sync header, validates the block type and the inter-block sequence, and emits XGMII receive words (32-bit data, 4-bit control) two per block.
- Mirror of the transmit encoder: same half order (bits [31:0] first), same sync header encoding.

---
 rtl/pcs_64b66b_decoder_if.sv | 25 ++
 rtl/pcs_64b66b_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_64b66b_decoder_if.sv
// Receive-side bus between the descrambler and the 64b/66b decoder, plus the XGMII
// receive word it produces. master = block source, slave = decoder.
interface pcs_64b66b_decoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr;
  logic                  i_rx_hdr_valid;
  logic                  i_rx_data_valid;
  logic [DATA_WIDTH-1:0] o_xgmii_rxd;
  logic [CTRL_WIDTH-1:0] o_xgmii_rxc;
  logic                  o_xgmii_valid;
  logic                  o_decoding_err;

  modport master (
    output i_rx_data, i_rx_sync_hdr, i_rx_hdr_valid, i_rx_data_valid,
    input  o_xgmii_rxd, o_xgmii_rxc, o_xgmii_valid, o_decoding_err
  );
  modport slave (
    input  i_rx_data, i_rx_sync_hdr, i_rx_hdr_valid, i_rx_data_valid,
    output o_xgmii_rxd, o_xgmii_rxc, o_xgmii_valid, o_decoding_err
  );
endinterface

// File: rtl/pcs_64b66b_decoder.sv
// 64b/66b receive block decoder: two-beat block capture, per-lane decode, sequence check.
// Define DECODER_ERR_CNT_EN to add the saturating o_err_count output.
module pcs_dec_lane #(
  parameter int LANE = 0
) (
  input  logic       i_data,
  input  logic       i_idle,
  input  logic       i_start0,
  input  logic       i_start4,
  input  logic       i_term,
  input  logic [2:0] i_term_k,
  input  logic [7:0] i_dbyte,
  input  logic [7:0] i_tbyte,
  input  logic [6:0] i_code,
  output logic [7:0] o_byte,
  output logic       o_ctrl
);
  localparam logic [2:0] LN = 3'(LANE);
  logic [7:0] w_cbyte;

  // only /I/ survives as a 7-bit control code; everything else reads as /E/
  assign w_cbyte = (i_code == 7'h00) ? 8'h07 : 8'hFE;

  always_comb begin
    o_byte = 8'h07;
    o_ctrl = 1'b1;
    if (i_data) begin
      o_byte = i_dbyte;
      o_ctrl = 1'b0;
    end else if (i_idle) begin
      o_byte = w_cbyte;
    end else if (i_start0) begin
      if (LANE == 0) o_byte = 8'hFB;
      else begin
        o_byte = i_dbyte;
        o_ctrl = 1'b0;
      end
    end else if (i_start4) begin
      if (LANE < 4)       o_byte = w_cbyte;
      else if (LANE == 4) o_byte = 8'hFB;
      else begin
        o_byte = i_dbyte;
        o_ctrl = 1'b0;
      end
    end else if (i_term) begin
      if (LN < i_term_k) begin
        o_byte = i_tbyte;
        o_ctrl = 1'b0;
      end else if (LN == i_term_k) begin
        o_byte = 8'hFD;
      end
    end
  end
endmodule

module pcs_64b66b_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int HDR_WIDTH  = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  pcs_64b66b_decoder_if.slave bus
`ifdef DECODER_ERR_CNT_EN
  , output logic [15:0] o_err_count
`endif
);
  localparam int NUM_LANES = 2 * CTRL_WIDTH;
  localparam logic [DATA_WIDTH-1:0] IDLE_W = {CTRL_WIDTH{8'h07}};
  localparam logic [DATA_WIDTH-1:0] ERR_W  = {CTRL_WIDTH{8'hFE}};

  typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;
  typedef enum logic [2:0] {BC_C, BC_S, BC_D, BC_T, BC_E} blk_class_t;

  rx_state_t  r_state, w_state_nxt;
  logic       r_phase, w_phase_nxt;
  blk_class_t w_class;

  logic [DATA_WIDTH-1:0]   r_lo;
  logic [HDR_WIDTH-1:0]    r_hdr;
  logic [2*DATA_WIDTH-1:0] w_blk;

  logic w_first, w_second, w_stray, w_resync, w_seq_err, w_err_nxt;
  logic w_ctl, w_data, w_idle, w_s0, w_s4, w_term, w_is_term;
  logic [2:0] w_term_k;

  logic [NUM_LANES-1:0][7:0] w_lane_byte;
  logic [NUM_LANES-1:0]      w_lane_ctrl;
  logic [2*DATA_WIDTH-1:0]   w_dec_rxd;
  logic [NUM_LANES-1:0]      w_dec_rxc;

  logic [DATA_WIDTH-1:0] r_rxd, r_hi_rxd;
  logic [CTRL_WIDTH-1:0] r_rxc, r_hi_rxc;
  logic                  r_valid, r_hi_pend, r_err;

  assign w_first  = bus.i_rx_data_valid &  bus.i_rx_hdr_valid;
  assign w_second = bus.i_rx_data_valid & ~bus.i_rx_hdr_valid &  r_phase;
  assign w_stray  = bus.i_rx_data_valid & ~bus.i_rx_hdr_valid & ~r_phase;
  assign w_resync = w_first & r_phase;
  // the upper half is decoded straight off the bus in the cycle it arrives
  assign w_blk    = {bus.i_rx_data, r_lo};

  always_comb begin
    w_is_term = 1'b1;
    w_term_k  = 3'd0;
    case (w_blk[7:0])
      8'h87:   w_term_k = 3'd0;
      8'h99:   w_term_k = 3'd1;
      8'hAA:   w_term_k = 3'd2;
      8'hB4:   w_term_k = 3'd3;
      8'hCC:   w_term_k = 3'd4;
      8'hD2:   w_term_k = 3'd5;
      8'hE1:   w_term_k = 3'd6;
      8'hFF:   w_term_k = 3'd7;
      default: w_is_term = 1'b0;
    endcase
  end

  assign w_data = (r_hdr == 2'b01);
  assign w_ctl  = (r_hdr == 2'b10);
  assign w_idle = w_ctl & (w_blk[7:0] == 8'h1E);
  assign w_s0   = w_ctl & (w_blk[7:0] == 8'h78);
  assign w_s4   = w_ctl & (w_blk[7:0] == 8'h33);
  assign w_term = w_ctl & w_is_term;

  always_comb begin
    w_class = BC_E;
    if (w_data)           w_class = BC_D;
    else if (w_idle)      w_class = BC_C;
    else if (w_s0 | w_s4) w_class = BC_S;
    else if (w_term)      w_class = BC_T;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RX_INIT;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_seq_err   = 1'b0;
    if (w_first)       w_phase_nxt = 1'b1;
    else if (w_second) w_phase_nxt = 1'b0;
    if (w_second) begin
      case (r_state)
        RX_INIT: begin
          if (w_class == BC_C) w_state_nxt = RX_C;
          else                 w_seq_err   = 1'b1;
        end
        RX_C, RX_T: begin
          if (w_class == BC_C)      w_state_nxt = RX_C;
          else if (w_class == BC_S) w_state_nxt = RX_D;
          else begin
            w_seq_err   = 1'b1;
            w_state_nxt = RX_E;
          end
        end
        RX_D: begin
          if (w_class == BC_D)      w_state_nxt = RX_D;
          else if (w_class == BC_T) w_state_nxt = RX_T;
          else begin
            w_seq_err   = 1'b1;
            w_state_nxt = RX_E;
          end
        end
        RX_E: begin
          if (w_class == BC_C)      w_state_nxt = RX_C;
          else if (w_class == BC_S) w_state_nxt = RX_D;
          else if (w_class == BC_T) w_state_nxt = RX_T;
          else                      w_seq_err   = 1'b1;
        end
        default: w_state_nxt = RX_INIT;
      endcase
    end
  end

  // all causes share one registered pulse, so coincident causes still give one pulse
  assign w_err_nxt = (w_second & w_seq_err) | w_resync | w_stray;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] w_tb;
    if (l < NUM_LANES - 1) begin : g_t
      assign w_tb = w_blk[8+8*l +: 8];
    end else begin : g_n
      assign w_tb = 8'h07;
    end
    pcs_dec_lane #(.LANE(l)) u_lane (
      .i_data   (w_data),
      .i_idle   (w_idle),
      .i_start0 (w_s0),
      .i_start4 (w_s4),
      .i_term   (w_term),
      .i_term_k (w_term_k),
      .i_dbyte  (w_blk[8*l +: 8]),
      .i_tbyte  (w_tb),
      .i_code   (w_blk[8+7*l +: 7]),
      .o_byte   (w_lane_byte[l]),
      .o_ctrl   (w_lane_ctrl[l])
    );
  end

  assign w_dec_rxd = w_seq_err ? {ERR_W, ERR_W} : w_lane_byte;
  assign w_dec_rxc = w_seq_err ? {NUM_LANES{1'b1}} : w_lane_ctrl;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lo      <= '0;
      r_hdr     <= '0;
      r_rxd     <= IDLE_W;
      r_rxc     <= '1;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_hi_rxd  <= IDLE_W;
      r_hi_rxc  <= '1;
      r_hi_pend <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (w_first) begin
        r_lo  <= bus.i_rx_data;
        r_hdr <= bus.i_rx_sync_hdr;
      end
      if (w_second) begin
        r_rxd     <= w_dec_rxd[DATA_WIDTH-1:0];
        r_rxc     <= w_dec_rxc[CTRL_WIDTH-1:0];
        r_valid   <= 1'b1;
        r_hi_rxd  <= w_dec_rxd[2*DATA_WIDTH-1:DATA_WIDTH];
        r_hi_rxc  <= w_dec_rxc[NUM_LANES-1:CTRL_WIDTH];
        r_hi_pend <= 1'b1;
      end else if (r_hi_pend) begin
        r_rxd     <= r_hi_rxd;
        r_rxc     <= r_hi_rxc;
        r_valid   <= 1'b1;
        r_hi_pend <= 1'b0;
      end else begin
        r_rxd     <= IDLE_W;
        r_rxc     <= '1;
        r_valid   <= 1'b0;
      end
    end
  end

  assign bus.o_xgmii_rxd    = r_rxd;
  assign bus.o_xgmii_rxc    = r_rxc;
  assign bus.o_xgmii_valid  = r_valid;
  assign bus.o_decoding_err = r_err;

`ifdef DECODER_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                            r_err_cnt <= '0;
    else if (w_err_nxt && r_err_cnt != '1)  r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign o_err_count = r_err_cnt;
`endif
endmodule
